// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline-control signals exchanged between the 5-stage core
//   datapath and the hazard controller.
//
//   Datapath -> controller (driven by the master):
//     id_rs, id_rt, id_uses_rs, id_uses_rt : register reads of the ID instruction
//     id_ex_mem_read, id_ex_rt             : load currently in EX and its target
//     id_jump                              : j/jal/jr sitting in ID
//     ex_branch_taken                      : branch in EX resolved taken
//     id_md_start, id_md_use               : mul/div issue and HI/LO consumers
//   Controller -> datapath (driven by the slave):
//     pc_write, if_id_write, if_id_flush, id_ex_flush : pipeline register control
//     md_busy                                         : mul/div unit occupied
//     stall_cycles, flush_cycles                      : performance counters
//
//   Handshake: there is no valid/ready pair here. Every control output is a
//   same-cycle decision that the datapath applies on the next rising clock
//   edge; inputs must be stable before that edge.
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        id_jump;
    logic        ex_branch_taken;
    logic        id_md_start;
    logic        id_md_use;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        md_busy;
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_ex_mem_read, id_ex_rt,
               id_jump, ex_branch_taken, id_md_start, id_md_use,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy,
               stall_cycles, flush_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_ex_mem_read, id_ex_rt,
               id_jump, ex_branch_taken, id_md_start, id_md_use,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy,
               stall_cycles, flush_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Central sequencing controller for the 5-stage MIPS pipeline. Holds fetch
//   during post-reset warm-up, inserts load-use bubbles, flushes on taken
//   branches and jumps, and interlocks HI/LO consumers against the multi-cycle
//   mul/div unit.
//
//   Ports:
//     clk       : clock
//     reset     : asynchronous, active-high reset
//     hz        : hazard_ctrl_if.slave, all pipeline control signals
//     dbg_state : current FSM state (0=INIT, 1=RUN, 2=MD_BUSY)
//
//   Parameters:
//     INIT_CYCLES : warm-up cycles after reset (1..15)
//     MD_LATENCY  : mul/div occupancy in cycles after issue (2..255)
//
//   Build option: define HAZARD_PERF_EN to build the stall/flush performance
//   counters; otherwise stall_cycles/flush_cycles read as 0 with no flops.
module hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int MD_LATENCY  = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MD_BUSY = 2'd2
    } state_e;

    localparam logic [7:0] INIT_CNT = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] MD_CNT   = 8'(MD_LATENCY - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic load_hz;
    logic md_hz;
    logic stall;
    logic md_issue;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;

    // Load-use: register 0 never carries a real dependency.
    assign load_hz = hz.id_ex_mem_read && (hz.id_ex_rt != 5'd0) &&
                     ((hz.id_uses_rs && (hz.id_rs == hz.id_ex_rt)) ||
                      (hz.id_uses_rt && (hz.id_rt == hz.id_ex_rt)));
    assign md_hz    = (state_q == ST_MD_BUSY) && hz.id_md_use;
    assign stall    = load_hz || md_hz;
    // A stalled or flushed mul/div never reaches the unit.
    assign md_issue = hz.id_md_start && !stall && !hz.ex_branch_taken;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (state_q == ST_INIT) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            cnt_d       = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
                state_d = ST_RUN;
                cnt_d   = 8'd0;
            end
        end else begin
            if (hz.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end else if (hz.id_jump) begin
                if_id_flush = 1'b1;
            end

            if (state_q == ST_RUN) begin
                if (md_issue) begin
                    state_d = ST_MD_BUSY;
                    cnt_d   = MD_CNT;
                end
            end else begin
                // An in-flight mul/div keeps counting even across a branch flush.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= INIT_CNT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.if_id_write = if_id_write;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.md_busy     = (state_q == ST_MD_BUSY);
    assign dbg_state      = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters saturate rather than wrap so a long run never reads as small.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ST_INIT) begin
            if (stall && !hz.ex_branch_taken && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_cycles = flush_cnt_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_cycles = 32'd0;
`endif

endmodule
